rr_bus_mux: RTL and testbench

Parametrised N-channel, W-bit bus multiplexer with round-robin arbitration and a one-entry registered output stage with valid/ready backpressure. It generalises the fixed 4-to-1 tristate select to N requesters. Each requester presents its own data and request, and the block picks the winner itself instead of taking an external select. It sits between several producers and one shared downstream consumer, such as a shared bus or a single-port sink.

---
 rtl/rr_bus_mux_pkg.sv | 35 +++
 rtl/rr_bus_mux_arbiter.sv | 55 +++++
 rtl/rr_bus_mux.sv | 105 ++++++++++
 tb/tb_rr_bus_mux.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/rr_bus_mux_pkg.sv
// rtl/rr_bus_mux_pkg.sv - shared constants and rotate-priority search for rr_bus_mux
// Contents:
//   RR_DEFAULT_N / RR_DEFAULT_W : default channel count and data width
//   RR_MAX_N                    : widest request mask rr_pick can search
//   rr_pick(req, ptr, n)        : first set bit of req in the order ptr..n-1, 0..ptr-1
package rr_bus_mux_pkg;

   localparam int RR_DEFAULT_N = 4;
   localparam int RR_DEFAULT_W = 8;
   localparam int RR_MAX_N     = 32;

   // Walks offsets from the far end back towards ptr so the lowest offset
   // with a request is the last one written and therefore wins. Returns ptr
   // when nothing is requested; callers gate the grant with |req.
   function automatic int rr_pick(input logic [RR_MAX_N-1:0] req,
                                  input int ptr,
                                  input int n);
      int idx;
      int pick;
      pick = ptr;
      for (int k = RR_MAX_N - 1; k >= 0; k--) begin
         if (k < n) begin
            idx = ptr + k;
            if (idx >= n) begin
               idx = idx - n;
            end
            if (req[idx]) begin
               pick = idx;
            end
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/rr_bus_mux_arbiter.sv
// rtl/rr_bus_mux_arbiter.sv - round-robin arbiter holding the priority pointer
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   req[N]          : per-channel request
//   advance         : a word was accepted this cycle; move the pointer past the winner
//   grant[N]        : one-hot winner, zero when req is zero
//   grant_idx_next  : binary index of the winner
module rr_arbiter
   import rr_bus_mux_pkg::*;
#(
   parameter int  N  = RR_DEFAULT_N,
   localparam int IW = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [N-1:0]  req,
   input  logic          advance,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] grant_idx_next
);

   logic [IW-1:0]       ptr_q;
   logic [IW-1:0]       ptr_d;
   logic [RR_MAX_N-1:0] req_ext;
   int                  win;

   always_comb begin
      req_ext        = '0;
      req_ext[N-1:0] = req;
      win            = rr_pick(req_ext, int'(ptr_q), N);
      grant_idx_next = IW'(win);
      grant          = '0;
      for (int i = 0; i < N; i++) begin
         grant[i] = (|req) && (win == i);
      end
   end

   // Explicit compare against N-1 so a non-power-of-two N wraps to 0
   // instead of walking into unused index values.
   always_comb begin
      ptr_d = ptr_q;
      if (advance && (|req)) begin
         ptr_d = (grant_idx_next == IW'(N - 1)) ? '0 : grant_idx_next + IW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/rr_bus_mux.sv
// rtl/rr_bus_mux.sv - N-channel round-robin bus mux with one registered output slot
// Build option: TRISTATE_BUS_EN selects the winner through bufif1 drivers onto a
// shared wire and floats dout while out_valid is low; otherwise an AND-OR mux.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   req[N]      : per-channel request; din[i*W +: W] is valid when req[i]
//   din[N*W]    : channel data
//   ack[N]      : combinational accept, at most one bit set, zero during reset
//   out_valid   : dout holds an unconsumed word
//   out_ready   : consumer takes the word this cycle
//   dout[W]     : registered output word
//   grant_idx   : channel that produced dout
module rr_bus_mux
   import rr_bus_mux_pkg::*;
#(
   parameter int  N  = RR_DEFAULT_N,
   parameter int  W  = RR_DEFAULT_W,
   localparam int IW = $clog2(N)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   req,
   input  logic [N*W-1:0] din,
   output logic [N-1:0]   ack,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [W-1:0]   dout,
   output logic [IW-1:0]  grant_idx
);

   logic [N-1:0]  grant;
   logic [IW-1:0] grant_idx_next;
   logic          accept;
   logic [W-1:0]  sel_data;

   logic          out_valid_q;
   logic          out_valid_d;
   logic [W-1:0]  dout_q;
   logic [W-1:0]  dout_d;
   logic [IW-1:0] grant_idx_q;
   logic [IW-1:0] grant_idx_d;

   // The slot can take a word when it is empty or being drained this cycle.
   assign accept = (|req) && (!out_valid_q || out_ready);
   assign ack    = rst ? '0 : (grant & {N{accept}});

   rr_arbiter #(.N(N)) u_arbiter (
      .clk            (clk),
      .rst            (rst),
      .req            (req),
      .advance        (accept),
      .grant          (grant),
      .grant_idx_next (grant_idx_next)
   );

`ifdef TRISTATE_BUS_EN
   // Shared bus floats when grant is zero; it is only sampled on accept,
   // which implies exactly one driver is enabled.
   wire [W-1:0] bus_w;
   for (genvar i = 0; i < N; i++) begin : g_drv
      for (genvar j = 0; j < W; j++) begin : g_bit
         bufif1 u_buf (bus_w[j], din[i*W + j], grant[i]);
      end
   end
   assign sel_data = bus_w;
   assign dout     = out_valid_q ? dout_q : {W{1'bz}};
`else
   always_comb begin
      sel_data = '0;
      for (int i = 0; i < N; i++) begin
         sel_data = sel_data | (din[i*W +: W] & {W{grant[i]}});
      end
   end
   assign dout = dout_q;
`endif

   assign out_valid = out_valid_q;
   assign grant_idx = grant_idx_q;

   always_comb begin
      out_valid_d = out_valid_q;
      dout_d      = dout_q;
      grant_idx_d = grant_idx_q;
      if (accept) begin
         out_valid_d = 1'b1;
         dout_d      = sel_data;
         grant_idx_d = grant_idx_next;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         dout_q      <= '0;
         grant_idx_q <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         dout_q      <= dout_d;
         grant_idx_q <= grant_idx_d;
      end
   end

endmodule

// File: tb/tb_rr_bus_mux.sv
// tb/tb_rr_bus_mux.sv - self-checking bench for rr_bus_mux (N=4 main, N=3 wrap)
module tb_rr_bus_mux;

   localparam int N = 4;
   localparam int W = 8;
`ifdef TRISTATE_BUS_EN
   localparam bit TRI_BUILD = 1'b1;
`else
   localparam bit TRI_BUILD = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req;
   logic [N*W-1:0] din;
   logic           out_ready;
   wire  [N-1:0]   ack;
   wire            out_valid;
   wire  [W-1:0]   dout;
   wire  [1:0]     grant_idx;

   logic [2:0]     req3;
   logic [3*W-1:0] din3;
   logic           rdy3;
   wire  [2:0]     ack3;
   wire            ov3;
   wire  [W-1:0]   dout3;
   wire  [1:0]     gi3;

   always #5 clk = ~clk;

   rr_bus_mux #(.N(N), .W(W)) dut (
      .clk(clk), .rst(rst), .req(req), .din(din), .ack(ack),
      .out_valid(out_valid), .out_ready(out_ready), .dout(dout), .grant_idx(grant_idx)
   );

   rr_bus_mux #(.N(3), .W(W)) dut3 (
      .clk(clk), .rst(rst), .req(req3), .din(din3), .ack(ack3),
      .out_valid(ov3), .out_ready(rdy3), .dout(dout3), .grant_idx(gi3)
   );

   int pass_cnt = 0;
   int total    = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic logic [W-1:0] exp_out(input logic v, input logic [W-1:0] d);
      if (TRI_BUILD && !v) return {W{1'bz}};
      return d;
   endfunction

   // Reference model: state of the single output slot and the priority pointer.
   int         m_ptr;
   logic       m_valid;
   logic [W-1:0] m_dout;
   int         m_gidx;

   task automatic model_reset();
      m_ptr = 0; m_valid = 1'b0; m_dout = '0; m_gidx = 0;
   endtask

   function automatic int winner(input logic [N-1:0] r, input int p);
      for (int k = 0; k < N; k++) begin
         if (r[(p + k) % N]) return (p + k) % N;
      end
      return -1;
   endfunction

   // One clock: drive at negedge, check ack before the edge, check registers after.
   task automatic cycle(input logic [N-1:0] r, input logic [N*W-1:0] d, input logic rdy,
                        input string tag);
      int w;
      bit acc;
      logic [N-1:0] e_ack;
      @(negedge clk);
      req = r; din = d; out_ready = rdy;
      #1;
      w   = winner(r, m_ptr);
      acc = (r != 0) && (!m_valid || rdy);
      e_ack = acc ? (N'(1) << w) : '0;
      chk({tag, ".ack"}, 64'(ack), 64'(e_ack));
      @(posedge clk);
      #1;
      if (acc) begin
         m_dout = d[w*W +: W]; m_gidx = w; m_valid = 1'b1; m_ptr = (w + 1) % N;
      end else if (m_valid && rdy) begin
         m_valid = 1'b0;
      end
      chk({tag, ".valid"}, 64'(out_valid), 64'(m_valid));
      chk({tag, ".dout"}, 64'(dout), 64'(exp_out(m_valid, m_dout)));
      chk({tag, ".gidx"}, 64'(grant_idx), 64'(m_gidx));
   endtask

   typedef struct {
      logic [N-1:0] r;
      logic         rdy;
      logic [N-1:0] e_ack;
      logic         e_valid;
      logic [W-1:0] e_dout;
      int           e_gidx;
   } vec_t;

   vec_t vecs[17];
   localparam logic [N*W-1:0] DIN_FIX = {8'h44, 8'h33, 8'h22, 8'h11};

   initial begin
      // Rotation through all four channels and back to 0.
      vecs[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 8'h11, 0};
      vecs[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 8'h22, 1};
      vecs[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 8'h33, 2};
      vecs[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 8'h44, 3};
      vecs[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 8'h11, 0};
      // Drain, then backpressure on channel 2 for five cycles, then drain.
      vecs[5]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 8'h11, 0};
      vecs[6]  = '{4'b0100, 1'b0, 4'b0100, 1'b1, 8'h33, 2};
      vecs[7]  = '{4'b0100, 1'b0, 4'b0000, 1'b1, 8'h33, 2};
      vecs[8]  = '{4'b0100, 1'b0, 4'b0000, 1'b1, 8'h33, 2};
      vecs[9]  = '{4'b0100, 1'b0, 4'b0000, 1'b1, 8'h33, 2};
      vecs[10] = '{4'b0100, 1'b0, 4'b0000, 1'b1, 8'h33, 2};
      vecs[11] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 8'h33, 2};
      // Fill, then drain and accept in the same cycle.
      vecs[12] = '{4'b0001, 1'b0, 4'b0001, 1'b1, 8'h11, 0};
      vecs[13] = '{4'b0010, 1'b1, 4'b0010, 1'b1, 8'h22, 1};
      // Pointer is now 2: channel 3 beats channel 0, then 0 beats 1.
      vecs[14] = '{4'b1011, 1'b1, 4'b1000, 1'b1, 8'h44, 3};
      vecs[15] = '{4'b0011, 1'b1, 4'b0001, 1'b1, 8'h11, 0};
      vecs[16] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 8'h11, 0};

      rst = 1'b1; req = '0; din = DIN_FIX; out_ready = 1'b0;
      req3 = '0; din3 = {8'hc3, 8'hb2, 8'ha1}; rdy3 = 1'b1;
      #1;
      chk("reset.valid", 64'(out_valid), 64'(0));
      chk("reset.gidx", 64'(grant_idx), 64'(0));
      chk("reset.dout", 64'(dout), 64'(exp_out(1'b0, 8'h00)));
      req = 4'b1111; out_ready = 1'b1; #1;
      chk("reset.ack", 64'(ack), 64'(0));
      req = '0;
      @(negedge clk); @(negedge clk);
      rst = 1'b0;

      // N=3 pointer wrap.
      req3 = 3'b111;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         chk($sformatf("n3[%0d].gidx", i), 64'(gi3), 64'(i % 3));
         chk($sformatf("n3[%0d].dout", i), 64'(dout3), 64'(8'ha1 + 8'(17 * (i % 3))));
         chk($sformatf("n3[%0d].valid", i), 64'(ov3), 64'(1));
      end
      @(negedge clk); req3 = '0;

      // Table-driven directed vectors on the N=4 instance.
      foreach (vecs[i]) begin
         @(negedge clk);
         req = vecs[i].r; din = DIN_FIX; out_ready = vecs[i].rdy;
         #1;
         chk($sformatf("vec%0d.ack", i), 64'(ack), 64'(vecs[i].e_ack));
         @(posedge clk); #1;
         chk($sformatf("vec%0d.valid", i), 64'(out_valid), 64'(vecs[i].e_valid));
         chk($sformatf("vec%0d.dout", i), 64'(dout),
             64'(exp_out(vecs[i].e_valid, vecs[i].e_dout)));
         chk($sformatf("vec%0d.gidx", i), 64'(grant_idx), 64'(vecs[i].e_gidx));
      end

      // Reset while a word is held under backpressure.
      @(negedge clk); rst = 1'b1; @(negedge clk); rst = 1'b0;
      model_reset();
      cycle(4'b1000, DIN_FIX, 1'b0, "hold3");
      @(negedge clk);
      req = 4'b1111; out_ready = 1'b0;
      rst = 1'b1; #1;
      chk("midrst.valid", 64'(out_valid), 64'(0));
      chk("midrst.gidx", 64'(grant_idx), 64'(0));
      chk("midrst.dout", 64'(dout), 64'(exp_out(1'b0, 8'h00)));
      chk("midrst.ack", 64'(ack), 64'(0));
      @(negedge clk); rst = 1'b0;
      model_reset();
      cycle(4'b1110, DIN_FIX, 1'b1, "post_rst_skip0");
      cycle(4'b1111, DIN_FIX, 1'b1, "post_rst_wrap");

      // Randomised traffic against the reference model.
      for (int i = 0; i < 400; i++) begin
         logic [N-1:0]   r;
         logic [N*W-1:0] d;
         logic           rdy;
         r   = N'($urandom);
         d   = {$urandom, $urandom};
         d   = d[N*W-1:0];
         rdy = ($urandom_range(0, 3) != 0);
         cycle(r, d, rdy, $sformatf("rand%0d", i));
      end

      // Idle: dout floats in the tristate build once the slot drains.
      cycle(4'b0000, DIN_FIX, 1'b1, "idle0");
      cycle(4'b0000, DIN_FIX, 1'b1, "idle1");

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
